// File: rtl/pipeline_stall_controller.sv
// Pipeline sequencer: merges memory wait, taken branch and load-use hazard into
// prioritised stage write-enables, flushes and bubbles, with saturating perf counters.
module pipeline_stall_controller #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_use_hazard,
    input  logic             branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_write,
    output logic             idex_flush,
    output logic             exmem_write,
    output logic             memwb_bubble,
    output logic [1:0]       state,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2,
        ILLEGAL  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic               mem_timeout_q, mem_timeout_d;
    logic [CNT_W-1:0]   stall_count_q, stall_count_d;
    logic [CNT_W-1:0]   flush_count_q, flush_count_d;
    logic               mem_stall;
    logic               branch_flush;

    assign mem_stall = dmem_req & ~dmem_ready;

    always_comb begin
        pc_write      = 1'b1;
        ifid_write    = 1'b1;
        ifid_flush    = 1'b0;
        idex_write    = 1'b1;
        idex_flush    = 1'b0;
        exmem_write   = 1'b1;
        memwb_bubble  = 1'b0;
        branch_flush  = 1'b0;
        state_d       = RUN;
        wait_cnt_d    = '0;

        if (reset) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_write  = 1'b0;
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            memwb_bubble = 1'b1;
        end else if (mem_stall) begin
            // Freeze everything upstream of MEM; younger requests are re-presented after release.
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_write  = 1'b0;
            memwb_bubble = 1'b1;
            state_d      = MEM_WAIT;
            wait_cnt_d   = (wait_cnt_q == WAIT_W'(MEM_TIMEOUT)) ? wait_cnt_q
                                                                : wait_cnt_q + WAIT_W'(1);
        end else if (state_q == ILLEGAL) begin
            state_d = RUN;
        end else if (branch_taken) begin
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            branch_flush = 1'b1;
        end else if (load_use_hazard && state_q != LU_STALL) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
            state_d    = LU_STALL;
        end

        mem_timeout_d = mem_timeout_q | (wait_cnt_d == WAIT_W'(MEM_TIMEOUT));
        stall_count_d = (!pc_write && stall_count_q != '1) ? stall_count_q + CNT_W'(1)
                                                           : stall_count_q;
        flush_count_d = (branch_flush && flush_count_q != '1) ? flush_count_q + CNT_W'(1)
                                                              : flush_count_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RUN;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign state       = state_q;
    assign mem_timeout = mem_timeout_q;
    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Randomised bench for pipeline_stall_controller against a cycle-level behavioural model
// (small counter width and timeout so saturation and timeout are reached quickly).
module tb_pipeline_stall_controller;

    localparam int CNT_W       = 3;
    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             load_use_hazard = 1'b0;
    logic             branch_taken = 1'b0;
    logic             dmem_req = 1'b0;
    logic             dmem_ready = 1'b0;
    logic             pc_write, ifid_write, ifid_flush, idex_write, idex_flush;
    logic             exmem_write, memwb_bubble, mem_timeout;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_count, flush_count;

    pipeline_stall_controller #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .load_use_hazard(load_use_hazard), .branch_taken(branch_taken),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_write(idex_write), .idex_flush(idex_flush), .exmem_write(exmem_write),
        .memwb_bubble(memwb_bubble), .state(state), .mem_timeout(mem_timeout),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: what happened last cycle, plus running totals.
    bit m_stalled_last;   // previous cycle was a load-use stall
    int m_wait_len;       // consecutive frozen cycles, capped at MEM_TIMEOUT
    bit m_timeout;
    int m_stalls;
    int m_flushes;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_stalled_last = 1'b0;
        m_wait_len     = 0;
        m_timeout      = 1'b0;
        m_stalls       = 0;
        m_flushes      = 0;
    endtask

    task automatic cycle(input bit r, input bit l, input bit b, input bit q, input bit y);
        bit freeze, flush, stall;
        bit e_pc, e_ifw, e_iff, e_idw, e_idf, e_exw, e_bub;
        int e_state;
        @(negedge clk);
        reset = r; load_use_hazard = l; branch_taken = b; dmem_req = q; dmem_ready = y;
        #1;
        freeze = !r && q && !y;
        flush  = !r && !freeze && b;
        stall  = !r && !freeze && !flush && l && !m_stalled_last;
        e_state = (m_wait_len > 0) ? 2 : (m_stalled_last ? 1 : 0);

        e_pc  = !(r || freeze || stall);
        e_ifw = !(r || freeze || stall);
        e_idw = !(r || freeze);
        e_exw = !(r || freeze);
        e_iff = r || flush;
        e_idf = r || flush || stall;
        e_bub = r || freeze;

        $display("t=%0t rst=%0b lu=%0b br=%0b req=%0b rdy=%0b | pcw=%0b st=%0d stall=%0d flush=%0d to=%0b",
                 $time, r, l, b, q, y, pc_write, state, stall_count, flush_count, mem_timeout);
        check("pc_write",     32'(pc_write),     32'(e_pc));
        check("ifid_write",   32'(ifid_write),   32'(e_ifw));
        check("ifid_flush",   32'(ifid_flush),   32'(e_iff));
        check("idex_write",   32'(idex_write),   32'(e_idw));
        check("idex_flush",   32'(idex_flush),   32'(e_idf));
        check("exmem_write",  32'(exmem_write),  32'(e_exw));
        check("memwb_bubble", 32'(memwb_bubble), 32'(e_bub));
        check("state",        32'(state),        32'(e_state));
        check("mem_timeout",  32'(mem_timeout),  32'(m_timeout));
        check("stall_count",  32'(stall_count),  32'(m_stalls));
        check("flush_count",  32'(flush_count),  32'(m_flushes));

        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            m_wait_len     = freeze ? ((m_wait_len < MEM_TIMEOUT) ? m_wait_len + 1 : m_wait_len) : 0;
            m_timeout      = m_timeout || (m_wait_len == MEM_TIMEOUT);
            if (!e_pc && m_stalls < CNT_MAX) m_stalls++;
            if (flush && m_flushes < CNT_MAX) m_flushes++;
            m_stalled_last = stall;
        end
    endtask

    initial begin
        @(posedge clk);
        model_reset();

        cycle(1, 0, 0, 0, 0);                  // reset state
        cycle(0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);                  // load-use: one stall then RUN
        cycle(0, 1, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 0);   // memory wait x3
        cycle(0, 0, 0, 1, 1);                  // release
        for (int i = 0; i < 2; i++) cycle(0, 1, 1, 1, 0);   // all three at once: freeze only
        cycle(0, 0, 1, 1, 1);                  // release with branch -> flush
        for (int i = 0; i < 6; i++) cycle(0, 0, 0, 1, 0);   // timeout
        cycle(0, 0, 0, 1, 1);
        cycle(0, 0, 0, 0, 0);                  // sticky after release
        for (int i = 0; i < 2; i++) cycle(0, 0, 0, 1, 0);
        cycle(1, 0, 0, 1, 0);                  // reset mid-wait
        cycle(0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);                  // reset mid-LU_STALL
        cycle(1, 1, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin     // saturation of stall_count
            cycle(0, 1, 0, 0, 0);
            cycle(0, 1, 0, 0, 0);
        end
        for (int i = 0; i < 10; i++) cycle(0, 0, 1, 0, 0);  // saturation of flush_count

        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 49) == 0),
                  ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 2) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
